// File: rtl/ps2_cmd_sequencer.sv
// rtl/ps2_cmd_sequencer.sv - PS/2 keyboard init / LED command sequencer with retries and timeouts
// Define PS2_LED_CMD_EN to build the LED-set command path; otherwise led_req/led_val are ignored.
module ps2_cmd_sequencer #(
   parameter int ACK_TIMEOUT = 100_000,
   parameter int BAT_TIMEOUT = 100_000_000,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_busy,
   input  logic       ps2_err,
   input  logic       read_data,
   input  logic [7:0] rx_data,
   output logic       write_data,
   output logic [7:0] tx_data,
   input  logic       init_req,
   input  logic       led_req,
   input  logic [2:0] led_val,
   output logic       led_ack,
   output logic       ready,
   output logic       error,
   output logic [7:0] rx_pass_data,
   output logic       rx_pass_valid
);
   localparam int TW = $clog2(BAT_TIMEOUT + 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   typedef enum logic [3:0] {
      RST_TX, RST_ACK, WAIT_BAT, IDLE,
      LED_CMD_TX, LED_CMD_ACK, LED_VAL_TX, LED_VAL_ACK, FAIL
   } state_t;

   state_t        state_q;
   logic [TW-1:0] timer_q;
   logic [RW-1:0] retry_q;
   logic          write_data_q;
   logic [7:0]    tx_data_q;
   logic          ready_q;
   logic          error_q;
   logic [7:0]    rx_pass_data_q;
   logic          rx_pass_valid_q;
`ifdef PS2_LED_CMD_EN
   logic          led_ack_q;
   logic [2:0]    led_val_q;
`endif

   logic ack_ok, ack_retry, retry_left;

   // An FA wins over a timeout or core error landing in the same cycle.
   assign ack_ok     = read_data && (rx_data == 8'hFA);
   assign ack_retry  = (read_data && (rx_data == 8'hFE)) || ps2_err || (timer_q == TW'(ACK_TIMEOUT));
   assign retry_left = retry_q < RW'(MAX_RETRY);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= RST_TX;
         timer_q         <= '0;
         retry_q         <= '0;
         write_data_q    <= 1'b0;
         tx_data_q       <= 8'h00;
         ready_q         <= 1'b0;
         error_q         <= 1'b0;
         rx_pass_data_q  <= 8'h00;
         rx_pass_valid_q <= 1'b0;
`ifdef PS2_LED_CMD_EN
         led_ack_q       <= 1'b0;
         led_val_q       <= 3'b000;
`endif
      end else begin
         write_data_q    <= 1'b0;
         rx_pass_valid_q <= 1'b0;
`ifdef PS2_LED_CMD_EN
         led_ack_q       <= 1'b0;
`endif
         if (timer_q != '1) timer_q <= timer_q + 1'b1;

         case (state_q)
            RST_TX: if (!ps2_busy) begin
               write_data_q <= 1'b1;
               tx_data_q    <= 8'hFF;
               state_q      <= RST_ACK;
               timer_q      <= '0;
            end
            RST_ACK: if (ack_ok) begin
               state_q <= WAIT_BAT;
               timer_q <= '0;
               retry_q <= '0;
            end else if (ack_retry) begin
               timer_q <= '0;
               if (retry_left) begin
                  retry_q <= retry_q + 1'b1;
                  state_q <= RST_TX;
               end else begin
                  state_q <= FAIL;
                  error_q <= 1'b1;
               end
            end
            WAIT_BAT: if (read_data && (rx_data == 8'hAA)) begin
               state_q <= IDLE;
               ready_q <= 1'b1;
               timer_q <= '0;
            end else if ((read_data && (rx_data == 8'hFC)) || (timer_q == TW'(BAT_TIMEOUT))) begin
               state_q <= FAIL;
               error_q <= 1'b1;
               timer_q <= '0;
            end
            IDLE: if (init_req) begin
               state_q <= RST_TX;
               ready_q <= 1'b0;
               timer_q <= '0;
               retry_q <= '0;
`ifdef PS2_LED_CMD_EN
            // led_req is still high while led_ack is visible; do not re-serve it then.
            end else if (led_req && !led_ack_q) begin
               led_val_q <= led_val;
               state_q   <= LED_CMD_TX;
               ready_q   <= 1'b0;
               timer_q   <= '0;
               retry_q   <= '0;
`endif
            end else if (read_data) begin
               rx_pass_valid_q <= 1'b1;
               rx_pass_data_q  <= rx_data;
            end
`ifdef PS2_LED_CMD_EN
            LED_CMD_TX: if (!ps2_busy) begin
               write_data_q <= 1'b1;
               tx_data_q    <= 8'hED;
               state_q      <= LED_CMD_ACK;
               timer_q      <= '0;
            end
            LED_CMD_ACK: if (ack_ok) begin
               state_q <= LED_VAL_TX;
               timer_q <= '0;
               retry_q <= '0;
            end else if (ack_retry) begin
               timer_q <= '0;
               if (retry_left) begin
                  retry_q <= retry_q + 1'b1;
                  state_q <= LED_CMD_TX;
               end else begin
                  state_q <= FAIL;
                  error_q <= 1'b1;
               end
            end
            LED_VAL_TX: if (!ps2_busy) begin
               write_data_q <= 1'b1;
               tx_data_q    <= {5'b00000, led_val_q};
               state_q      <= LED_VAL_ACK;
               timer_q      <= '0;
            end
            LED_VAL_ACK: if (ack_ok) begin
               state_q   <= IDLE;
               ready_q   <= 1'b1;
               led_ack_q <= 1'b1;
               timer_q   <= '0;
               retry_q   <= '0;
            end else if (ack_retry) begin
               timer_q <= '0;
               if (retry_left) begin
                  retry_q <= retry_q + 1'b1;
                  state_q <= LED_VAL_TX;
               end else begin
                  state_q <= FAIL;
                  error_q <= 1'b1;
               end
            end
`endif
            FAIL: if (init_req) begin
               state_q <= RST_TX;
               error_q <= 1'b0;
               timer_q <= '0;
               retry_q <= '0;
            end
            default: begin
               state_q <= RST_TX;
               ready_q <= 1'b0;
               timer_q <= '0;
               retry_q <= '0;
            end
         endcase
      end
   end

   assign write_data    = write_data_q;
   assign tx_data       = tx_data_q;
   assign ready         = ready_q;
   assign error         = error_q;
   assign rx_pass_data  = rx_pass_data_q;
   assign rx_pass_valid = rx_pass_valid_q;
`ifdef PS2_LED_CMD_EN
   assign led_ack       = led_ack_q;
`else
   logic unused_led;
   assign unused_led    = ^{led_req, led_val};
   assign led_ack       = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// tb/tb_ps2_cmd_sequencer.sv - directed self-checking bench for ps2_cmd_sequencer
module tb_ps2_cmd_sequencer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ps2_busy = 1'b0;
   logic       ps2_err = 1'b0;
   logic       read_data = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       init_req = 1'b0;
   logic       led_req = 1'b0;
   logic [2:0] led_val = 3'b000;
   logic       write_data, led_ack, ready, error, rx_pass_valid;
   logic [7:0] tx_data, rx_pass_data;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int ack_cnt = 0;
   int pass_cnt = 0;
   int stamp [64];
   logic [7:0] wr_byte [64];
   int base, g;

   ps2_cmd_sequencer #(.ACK_TIMEOUT(50), .BAT_TIMEOUT(500), .MAX_RETRY(3)) dut (
      .clk(clk), .rst(rst), .ps2_busy(ps2_busy), .ps2_err(ps2_err),
      .read_data(read_data), .rx_data(rx_data), .write_data(write_data), .tx_data(tx_data),
      .init_req(init_req), .led_req(led_req), .led_val(led_val), .led_ack(led_ack),
      .ready(ready), .error(error), .rx_pass_data(rx_pass_data), .rx_pass_valid(rx_pass_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (write_data) begin
         stamp[wr_cnt % 64]   = cyc;
         wr_byte[wr_cnt % 64] = tx_data;
         wr_cnt++;
      end
      if (led_ack) ack_cnt++;
      if (rx_pass_valid) pass_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      read_data = 1'b1;
      rx_data   = b;
      tick();
      read_data = 1'b0;
   endtask

   task automatic wait_wr(input string tag, input int target);
      for (int i = 0; i < 400 && wr_cnt < target; i++) tick();
      chk(tag, 32'(wr_cnt >= target), 32'd1);
   endtask

   task automatic do_reset();
      #1;
      rst = 1'b0;
      repeat (3) tick();
      base = wr_cnt;
      rst = 1'b1;
   endtask

   task automatic bring_up(input string tag);
      do_reset();
      wait_wr(tag, base + 1);
      send_byte(8'hFA);
      tick();
      send_byte(8'hAA);
      chk(tag, {31'd0, ready}, 32'd1);
   endtask

   initial begin
      tick();
      chk("rst_write_data", {31'd0, write_data}, 32'd0);
      chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
      chk("rst_ready_error", {30'd0, ready, error}, 32'd0);
      chk("rst_led_ack_pass", {30'd0, led_ack, rx_pass_valid}, 32'd0);
      chk("rst_pass_data", {24'd0, rx_pass_data}, 32'h00);

      // Normal init: first write in cycle 1 after release
      base = wr_cnt;
      rst = 1'b1;
      tick();
      chk("first_write_cycle1", {31'd0, write_data}, 32'd1);
      chk("first_write_byte", {24'd0, tx_data}, 32'hFF);
      tick();
      chk("write_one_cycle", {31'd0, write_data}, 32'd0);
      send_byte(8'hFA);
      chk("ready_in_wait_bat", {31'd0, ready}, 32'd0);
      send_byte(8'hAA);
      chk("normal_ready", {30'd0, ready, error}, 32'b10);
      chk("normal_writes", 32'(wr_cnt - base), 32'd1);

      // Passthrough in IDLE
      g = pass_cnt;
      send_byte(8'h1C);
      chk("pass_valid", {31'd0, rx_pass_valid}, 32'd1);
      chk("pass_data", {24'd0, rx_pass_data}, 32'h1C);
      tick();
      chk("pass_pulse_once", 32'(pass_cnt - g), 32'd1);

      // Resend: FE, FE, FA, AA
      do_reset();
      wait_wr("resend_w1", base + 1);
      send_byte(8'hFE);
      wait_wr("resend_w2", base + 2);
      send_byte(8'hFE);
      wait_wr("resend_w3", base + 3);
      send_byte(8'hFA);
      send_byte(8'hAA);
      repeat (60) tick();
      chk("resend_writes", 32'(wr_cnt - base), 32'd3);
      chk("resend_ready", {30'd0, ready, error}, 32'b10);

      // Silent keyboard: four FF writes, then FAIL
      do_reset();
      wait_wr("silent_w4", base + 4);
      for (int k = 1; k < 4; k++) begin
         g = stamp[(base + k) % 64] - stamp[(base + k - 1) % 64];
         chk("silent_gap", 32'(g >= 51 && g <= 53), 32'd1);
      end
      chk("silent_byte", {24'd0, wr_byte[(base + 3) % 64]}, 32'hFF);
      for (int i = 0; i < 150 && !error; i++) tick();
      chk("silent_error", {30'd0, ready, error}, 32'b01);
      repeat (60) tick();
      chk("silent_no_5th", 32'(wr_cnt - base), 32'd4);
      base = wr_cnt;
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
      wait_wr("reinit_w", base + 1);
      chk("reinit_byte", {24'd0, wr_byte[base % 64]}, 32'hFF);
      send_byte(8'hFA);
      send_byte(8'hAA);
      chk("reinit_ready", {30'd0, ready, error}, 32'b10);

      // BAT fail by FC, and passthrough suppressed in WAIT_BAT
      do_reset();
      wait_wr("bat_fc_w", base + 1);
      send_byte(8'hFA);
      g = pass_cnt;
      send_byte(8'h1C);
      tick();
      chk("no_pass_wait_bat", 32'(pass_cnt - g), 32'd0);
      send_byte(8'hFC);
      chk("bat_fc_error", {30'd0, ready, error}, 32'b01);

      // BAT timeout
      do_reset();
      wait_wr("bat_to_w", base + 1);
      send_byte(8'hFA);
      repeat (490) tick();
      chk("bat_to_before", {31'd0, error}, 32'd0);
      repeat (30) tick();
      chk("bat_to_error", {30'd0, ready, error}, 32'b01);

`ifdef PS2_LED_CMD_EN
      // LED sequence ED, 05, single led_ack
      bring_up("led_up");
      base = wr_cnt;
      g = ack_cnt;
      led_val = 3'b101;
      led_req = 1'b1;
      wait_wr("led_w1", base + 1);
      chk("led_cmd_byte", {24'd0, wr_byte[base % 64]}, 32'hED);
      send_byte(8'hFA);
      wait_wr("led_w2", base + 2);
      chk("led_val_byte", {24'd0, wr_byte[(base + 1) % 64]}, 32'h05);
      send_byte(8'hFA);
      chk("led_ack_pulse", {31'd0, led_ack}, 32'd1);
      led_req = 1'b0;
      repeat (20) tick();
      chk("led_ack_once", 32'(ack_cnt - g), 32'd1);
      chk("led_writes", 32'(wr_cnt - base), 32'd2);
      chk("led_ready", {31'd0, ready}, 32'd1);

      // init_req wins over simultaneous led_req
      base = wr_cnt;
      led_req = 1'b1;
      init_req = 1'b1;
      tick();
      init_req = 1'b0;
      wait_wr("prio_w", base + 1);
      chk("prio_byte", {24'd0, wr_byte[base % 64]}, 32'hFF);
      led_req = 1'b0;
      send_byte(8'hFA);
      send_byte(8'hAA);
      chk("prio_ready", {31'd0, ready}, 32'd1);
`else
      // LED path absent: led_req is ignored
      bring_up("led_up");
      base = wr_cnt;
      led_val = 3'b101;
      led_req = 1'b1;
      repeat (40) tick();
      led_req = 1'b0;
      chk("led_ignored_writes", 32'(wr_cnt - base), 32'd0);
      chk("led_ack_zero", 32'(ack_cnt), 32'd0);
      chk("led_ignored_ready", {31'd0, ready}, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
